// File: rtl/param_frame_aligner.sv
// param_frame_aligner: word-serial frame aligner for a receive stream.
// It hunts for a multi-word header and needs SYNC_FRAMES consecutive good
// headers to declare sync. In sync it reports each word's position in the
// frame, and it drops sync after LOSS_FRAMES consecutive bad headers.
// Optional build macro FA_HDR_ERR_CNT_EN adds a saturating counter of bad
// headers seen in sync. Without the macro, hdr_err_cnt is tied to zero.
`timescale 1ns/1ps
module param_frame_aligner #(
  parameter int                          DATA_W      = 8,
  parameter int                          HDR_LEN     = 2,
  parameter logic [HDR_LEN*DATA_W-1:0]   HDR_PATTERN = 16'hAFAA,
  parameter int                          FRAME_LEN   = 12,
  parameter int                          SYNC_FRAMES = 3,
  parameter int                          LOSS_FRAMES = 4,
  parameter int                          ERR_CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_W-1:0]            rx_data,
  input  logic                         rx_valid,
  output logic                         frame_detect,
  output logic [$clog2(FRAME_LEN)-1:0] fr_byte_position,
  output logic [1:0]                   sync_state,
  output logic                         sync_lost,
  output logic [ERR_CNT_W-1:0]         hdr_err_cnt
);

  localparam int POS_W  = $clog2(FRAME_LEN);
  localparam int GOOD_W = $clog2(SYNC_FRAMES + 1);
  localparam int MISS_W = $clog2(LOSS_FRAMES + 1);

  localparam logic [POS_W-1:0]  CHECK_POS   = POS_W'(HDR_LEN - 1);
  localparam logic [POS_W-1:0]  LAST_POS    = POS_W'(FRAME_LEN - 1);
  localparam logic [GOOD_W-1:0] GOOD_TARGET = GOOD_W'(SYNC_FRAMES);
  localparam logic [MISS_W-1:0] MISS_LIMIT  = MISS_W'(LOSS_FRAMES);

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    VERIFY = 2'b01,
    SYNC   = 2'b10
  } state_t;

  state_t             state, state_nxt;
  logic [POS_W-1:0]   pos, pos_nxt, pos_inc;
  logic [GOOD_W-1:0]  good_cnt, good_nxt;
  logic [MISS_W-1:0]  miss_cnt, miss_nxt;
  logic               lost_nxt;
  logic               hdr_match;
  logic               at_check;

  // The header window is the current word plus the previous HDR_LEN-1
  // accepted words, with the oldest word in the least-significant slice.
  // The word that drops out of the window never takes part in a comparison,
  // so only HDR_LEN-1 words of history are stored.
  if (HDR_LEN == 1) begin : g_no_hist
    assign hdr_match = (rx_data == HDR_PATTERN);
  end else begin : g_hist
    localparam int HIST_W = (HDR_LEN - 1) * DATA_W;
    logic [HIST_W-1:0]         hist;
    logic [HDR_LEN*DATA_W-1:0] window;

    assign window    = {rx_data, hist};
    assign hdr_match = (window == HDR_PATTERN);

    // Shift each accepted word into the history, discarding the oldest.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
      if (reset)         hist <= '0;
      else if (rx_valid) hist <= window[HDR_LEN*DATA_W-1 -: HIST_W];
    end
  end

  // Position of the incoming word, and whether it lands on the header check point.
  assign pos_inc  = (pos == LAST_POS) ? '0 : pos + POS_W'(1);
  assign at_check = (pos_inc == CHECK_POS);

  // State, position and counter registers. They only move on accepted words.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= HUNT;
      pos       <= '0;
      good_cnt  <= '0;
      miss_cnt  <= '0;
      sync_lost <= 1'b0;
    end else begin
      state     <= state_nxt;
      pos       <= pos_nxt;
      good_cnt  <= good_nxt;
      miss_cnt  <= miss_nxt;
      sync_lost <= lost_nxt;
    end
  end

  // Next-state logic: hunt on every word, then verify and track only at the check point.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one unassigned (no latch).
    state_nxt = state;
    pos_nxt   = pos;
    good_nxt  = good_cnt;
    miss_nxt  = miss_cnt;
    lost_nxt  = 1'b0;
    if (rx_valid) begin
      unique case (state)
        HUNT: begin
          pos_nxt = '0;
          if (hdr_match) begin
            pos_nxt   = CHECK_POS;
            good_nxt  = GOOD_W'(1);
            miss_nxt  = '0;
            state_nxt = (SYNC_FRAMES == 1) ? SYNC : VERIFY;
          end
        end
        VERIFY: begin
          pos_nxt = pos_inc;
          if (at_check) begin
            if (hdr_match) begin
              good_nxt = good_cnt + GOOD_W'(1);
              if (good_cnt + GOOD_W'(1) == GOOD_TARGET) begin
                state_nxt = SYNC;
                good_nxt  = '0;
                miss_nxt  = '0;
              end
            end else begin
              state_nxt = HUNT;
              good_nxt  = '0;
              pos_nxt   = '0;
            end
          end
        end
        SYNC: begin
          pos_nxt = pos_inc;
          if (at_check) begin
            if (hdr_match) begin
              miss_nxt = '0;
            end else if (miss_cnt + MISS_W'(1) == MISS_LIMIT) begin
              // Last allowed miss: give up the phase and resume hunting.
              state_nxt = HUNT;
              pos_nxt   = '0;
              miss_nxt  = '0;
              lost_nxt  = 1'b1;
            end else begin
              miss_nxt = miss_cnt + MISS_W'(1);
            end
          end
        end
        default: begin
          state_nxt = HUNT;
          pos_nxt   = '0;
        end
      endcase
    end
  end

  assign frame_detect     = (state == SYNC);
  assign fr_byte_position = pos;
  assign sync_state       = state;

`ifdef FA_HDR_ERR_CNT_EN
  logic sync_miss;
  assign sync_miss = rx_valid && (state == SYNC) && at_check && !hdr_match;

  // Saturating count of bad headers seen in sync. Only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             hdr_err_cnt <= '0;
    else if (sync_miss && !(&hdr_err_cnt)) hdr_err_cnt <= hdr_err_cnt + ERR_CNT_W'(1);
  end
`else
  assign hdr_err_cnt = '0;
`endif

endmodule

// File: tb/tb_param_frame_aligner.sv
// Self-checking bench for param_frame_aligner.
// DUT "a" uses the default parameters and is checked every cycle against a
// behavioural model. DUT "b" is a wide, single-frame-sync configuration and
// is exercised with directed checks, including a reset in mid-frame.
`timescale 1ns/1ps
module tb_param_frame_aligner;

  localparam int          A_FL  = 12;
  localparam int          A_HL  = 2;
  localparam int          A_SF  = 3;
  localparam int          A_LF  = 4;
  localparam logic [15:0] A_PAT = 16'hAFAA;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT a: default configuration
  logic        reset_a, a_valid, a_fd, a_lost;
  logic [7:0]  a_data;
  logic [3:0]  a_pos;
  logic [1:0]  a_state;
  logic [15:0] a_err;

  param_frame_aligner dut_a (
    .clk(clk), .reset(reset_a), .rx_data(a_data), .rx_valid(a_valid),
    .frame_detect(a_fd), .fr_byte_position(a_pos), .sync_state(a_state),
    .sync_lost(a_lost), .hdr_err_cnt(a_err)
  );

  // DUT b: 16-bit words, 3-word header, 20-word frame, sync on first match
  logic        reset_b, b_valid, b_fd, b_lost;
  logic [15:0] b_data;
  logic [4:0]  b_pos;
  logic [1:0]  b_state;
  logic [15:0] b_err;

  param_frame_aligner #(
    .DATA_W(16), .HDR_LEN(3), .HDR_PATTERN(48'h1234_5678_9ABC),
    .FRAME_LEN(20), .SYNC_FRAMES(1)
  ) dut_b (
    .clk(clk), .reset(reset_b), .rx_data(b_data), .rx_valid(b_valid),
    .frame_detect(b_fd), .fr_byte_position(b_pos), .sync_state(b_state),
    .sync_lost(b_lost), .hdr_err_cnt(b_err)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model of DUT a: mode 0 hunt, 1 verify, 2 sync.
  int         m_state, m_pos, m_good, m_miss, m_err;
  bit         m_lost;
  logic [7:0] m_hist[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_state = 0; m_pos = 0; m_good = 0; m_miss = 0; m_err = 0; m_lost = 0;
    m_hist.delete();
  endfunction

  function automatic void model_step(input logic [7:0] d, input bit v);
    bit hdr;
    m_lost = 0;
    if (!v) return;
    hdr = (m_hist.size() >= A_HL - 1) && ({d, m_hist[m_hist.size()-1]} == A_PAT);
    case (m_state)
      0: begin
        m_pos = 0;
        if (hdr) begin
          m_pos = A_HL - 1; m_good = 1; m_miss = 0;
          m_state = (A_SF == 1) ? 2 : 1;
        end
      end
      1: begin
        m_pos = (m_pos + 1) % A_FL;
        if (m_pos == A_HL - 1) begin
          if (hdr) begin
            m_good++;
            if (m_good == A_SF) begin m_state = 2; m_miss = 0; end
          end else begin
            m_state = 0; m_good = 0; m_pos = 0;
          end
        end
      end
      default: begin
        m_pos = (m_pos + 1) % A_FL;
        if (m_pos == A_HL - 1) begin
          if (hdr) m_miss = 0;
          else begin
            m_miss++;
            if (m_err < 65535) m_err++;
            if (m_miss == A_LF) begin
              m_state = 0; m_pos = 0; m_miss = 0; m_lost = 1;
            end
          end
        end
      end
    endcase
    m_hist.push_back(d);
    if (m_hist.size() > A_HL) void'(m_hist.pop_front());
  endfunction

  task automatic check_a(input string tag);
    check({tag, "_fd"},    a_fd,    (m_state == 2));
    check({tag, "_pos"},   a_pos,   m_pos);
    check({tag, "_state"}, a_state, m_state);
    check({tag, "_lost"},  a_lost,  m_lost);
`ifdef FA_HDR_ERR_CNT_EN
    check({tag, "_err"},   a_err,   m_err);
`else
    check({tag, "_err"},   a_err,   0);
`endif
  endtask

  // One clock of stimulus on DUT a, then compare every output with the model.
  task automatic step_a(input logic [7:0] d, input bit v);
    @(negedge clk);
    a_data = d; a_valid = v;
    @(posedge clk);
    model_step(d, v);
    #1 check_a("a");
  endtask

  // Accepted word, optionally followed by an idle (rx_valid=0) cycle.
  task automatic word_a(input logic [7:0] d, input bit gappy);
    step_a(d, 1'b1);
    if (gappy) step_a(8'($urandom), 1'b0);
  endtask

  function automatic logic [7:0] payload();
    logic [7:0] p;
    do p = 8'($urandom); while (p == 8'hAA);
    return p;
  endfunction

  task automatic pay_a(input int n, input bit gappy);
    for (int i = 0; i < n; i++) word_a(payload(), gappy);
  endtask

  task automatic frame_a(input logic [7:0] h1, input bit gappy);
    word_a(8'hAA, gappy);
    word_a(h1, gappy);
    pay_a(A_FL - 2, gappy);
  endtask

  task automatic step_b(input logic [15:0] d);
    @(negedge clk);
    b_data = d; b_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_a = 1'b1; reset_b = 1'b1;
    a_valid = 1'b0; a_data = '0; b_valid = 1'b0; b_data = '0;
    model_reset();
    #2 check_a("reset");
    @(negedge clk) reset_a = 1'b0;

    // Clean stream: HUNT -> VERIFY -> SYNC.
    frame_a(8'hAF, 0);
    check("t1_verify", a_state, 2'b01);
    frame_a(8'hAF, 0);
    word_a(8'hAA, 0);
    check("t1_fd_early", a_fd, 1'b0);
    word_a(8'hAF, 0);
    check("t1_fd_rise", a_fd, 1'b1);
    check("t1_sync", a_state, 2'b10);
    pay_a(A_FL - 2, 0);
    check("t1_pos_last", a_pos, 4'd11);
    frame_a(8'hAF, 0);

    // Three bad headers, then a good one: sync holds.
    for (int f = 0; f < 3; f++) frame_a(8'h55, 0);
    frame_a(8'hAF, 0);
    check("t2_fd_hold", a_fd, 1'b1);
`ifdef FA_HDR_ERR_CNT_EN
    check("t2_err3", a_err, 16'd3);
`else
    check("t2_err0", a_err, 16'd0);
`endif

    // Four bad headers: loss of sync.
    for (int f = 0; f < 3; f++) frame_a(8'h55, 0);
    word_a(8'hAA, 0);
    word_a(8'h55, 0);
    check("t3_lost", a_lost, 1'b1);
    check("t3_fd", a_fd, 1'b0);
    check("t3_hunt", a_state, 2'b00);
    check("t3_pos", a_pos, 4'd0);
    word_a(payload(), 0);
    check("t3_lost_pulse", a_lost, 1'b0);
    pay_a(A_FL - 3, 0);

    // VERIFY with a bad second header returns to HUNT.
    frame_a(8'hAF, 0);
    word_a(8'hAA, 0);
    word_a(8'h55, 0);
    check("t4_back_hunt", a_state, 2'b00);
    pay_a(A_FL - 2, 0);

    // Regain sync, then place a header at positions 4/5: ignored.
    for (int f = 0; f < 3; f++) frame_a(8'hAF, 0);
    word_a(8'hAA, 0);
    word_a(8'hAF, 0);
    pay_a(2, 0);
    word_a(8'hAA, 0);
    word_a(8'hAF, 0);
    check("t4_fake_pos", a_pos, 4'd5);
    check("t4_fake_sync", a_state, 2'b10);
    pay_a(A_FL - 6, 0);
    frame_a(8'hAF, 0);

    // Reset in mid-frame clears the outputs at once, then sync again with idle gaps.
    pay_a(3, 0);
    @(posedge clk);
    #2 reset_a = 1'b1;
    model_reset();
    #1 check_a("t5_async");
    @(negedge clk) reset_a = 1'b0;
    frame_a(8'hAF, 1);
    frame_a(8'hAF, 1);
    word_a(8'hAA, 1);
    check("t5_still_verify", a_state, 2'b01);
    word_a(8'hAF, 1);
    check("t5_sync", a_state, 2'b10);
    check("t5_pos", a_pos, 4'd1);
    pay_a(A_FL - 2, 1);

    // Random frames, corrupt headers, idle gaps and arbitrary payload.
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < A_FL; i++) begin
        logic [7:0] d;
        if (i == 0)      d = 8'hAA;
        else if (i == 1) d = ($urandom_range(0, 3) == 0) ? 8'h55 : 8'hAF;
        else             d = 8'($urandom);
        step_a(d, 1'b1);
        if ($urandom_range(0, 3) == 0) step_a(8'($urandom), 1'b0);
      end
    end

    // DUT b: sync on the first match, then reset in mid-frame.
    @(negedge clk) reset_b = 1'b0;
    step_b(16'h0001);
    check("b_hunt0", b_state, 2'b00);
    step_b(16'h9ABC);
    step_b(16'h5678);
    check("b_hunt1", b_state, 2'b00);
    step_b(16'h1234);
    check("b_sync", b_state, 2'b10);
    check("b_fd", b_fd, 1'b1);
    check("b_pos2", b_pos, 5'd2);
    check("b_nolost", b_lost, 1'b0);
    for (int i = 0; i < 6; i++) step_b(16'($urandom));
    check("b_pos8", b_pos, 5'd8);
    @(posedge clk);
    #2 reset_b = 1'b1;
    #1;
    check("b_rst_fd", b_fd, 1'b0);
    check("b_rst_state", b_state, 2'b00);
    check("b_rst_pos", b_pos, 5'd0);
    check("b_rst_lost", b_lost, 1'b0);
    check("b_rst_err", b_err, 16'd0);
    @(negedge clk) reset_b = 1'b0;
    step_b(16'h5678);
    step_b(16'h9ABC);
    step_b(16'h5678);
    check("b_rehunt", b_state, 2'b00);
    step_b(16'h1234);
    check("b_resync", b_state, 2'b10);
    check("b_repos", b_pos, 5'd2);
    for (int i = 0; i < 17; i++) step_b(16'($urandom));
    check("b_pos19", b_pos, 5'd19);
    step_b(16'h9ABC);
    check("b_wrap", b_pos, 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
